tinker_fetch_queue: RTL and testbench

TINKER_FETCH_QUEUE -- requirements
Module: tinker_fetch_queue

---
 rtl/tinker_pkg.sv | 22 ++
 rtl/tinker_fetch_queue_if.sv | 39 +++
 rtl/tinker_fq_ring.sv | 52 +++++
 rtl/tinker_fetch_queue.sv | 150 +++++++++++++++
 tb/tb_tinker_fetch_queue.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tinker_pkg.sv
// Shared types and constants for the tinker fetch front end.
package tinker_pkg;

    typedef logic [63:0] addr_t;
    typedef logic [31:0] instr_t;

    localparam addr_t TINKER_RESET_PC = 64'h2000;

    // Bound on responses still owed by memory for requests killed by redirects
    localparam int unsigned FQ_STALE_W = 8;

    typedef enum logic [0:0] {
        FQ_FETCH = 1'b0,
        FQ_HOLD  = 1'b1
    } fq_state_t;

    typedef struct packed {
        addr_t  pc;
        instr_t instr;
    } fq_entry_t;

endpackage

// File: rtl/tinker_fetch_queue_if.sv
// Memory request/response and decoder-facing handshake bundle of the fetch queue.
interface tinker_fetch_queue_if;
    import tinker_pkg::*;

    logic   mem_req_valid;
    addr_t  mem_req_addr;
    logic   mem_req_ready;
    logic   mem_rsp_valid;
    instr_t mem_rsp_data;
    logic   out_valid;
    instr_t out_instr;
    addr_t  out_pc;
    logic   out_ready;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        input  mem_req_ready,
        input  mem_rsp_valid,
        input  mem_rsp_data,
        output out_valid,
        output out_instr,
        output out_pc,
        input  out_ready
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        output mem_req_ready,
        output mem_rsp_valid,
        output mem_rsp_data,
        input  out_valid,
        input  out_instr,
        input  out_pc,
        output out_ready
    );

endinterface

// File: rtl/tinker_fq_ring.sv
// Circular buffer of {pc, instr} entries; pointers wrap naturally at a power-of-two DEPTH.
module tinker_fq_ring
    import tinker_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  fq_entry_t        push_entry,
    input  logic             pop,
    output fq_entry_t        head_entry,
    output logic [CNT_W-1:0] count
);

    fq_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    // Pointer and occupancy update; clear wins over a same-cycle push/pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[tail] <= push_entry;
        end
    end

    assign head_entry = mem[head];

endmodule

// File: rtl/tinker_fetch_queue.sv
// Instruction fetch queue: credit-limited in-order requests, redirect with stale-response drop, halt hold.
// Define TINKER_FQ_BYPASS_EN to forward a live response straight to the decoder when the queue is empty.
module tinker_fetch_queue
    import tinker_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter addr_t       RESET_PC = TINKER_RESET_PC
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  addr_t                flush_pc,
    input  logic                 halt,
    tinker_fetch_queue_if.master bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    fq_state_t        state;
    fq_state_t        state_next;
    addr_t            fetch_pc;
    logic [CNT_W-1:0] outstanding;
    logic [FQ_STALE_W-1:0] stale;
    logic [CNT_W-1:0] count;
    fq_entry_t        head_entry;
    fq_entry_t        push_entry;

    logic   credit_ok_c;
    logic   req_valid_c;
    logic   req_fire_c;
    logic   rsp_live_c;
    logic   rsp_stale_c;
    logic   bypass_hit_c;
    logic   push_c;
    logic   pop_c;
    addr_t  rsp_pc_c;
    logic   out_valid_c;
    addr_t  out_pc_c;
    instr_t out_instr_c;

    assign credit_ok_c = (SUM_W'(count) + SUM_W'(outstanding)) < SUM_W'(DEPTH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FQ_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next state and request strobe; flush overrides halt and blocks issue this cycle
    always_comb begin
        state_next  = state;
        req_valid_c = 1'b0;
        case (state)
            FQ_FETCH: begin
                if (flush) begin
                    state_next = FQ_FETCH;
                end else if (halt) begin
                    state_next = FQ_HOLD;
                end else begin
                    req_valid_c = credit_ok_c;
                end
            end
            FQ_HOLD: begin
                if (flush) begin
                    state_next = FQ_FETCH;
                end
            end
            default: state_next = FQ_FETCH;
        endcase
    end

    assign bus.mem_req_valid = req_valid_c & ~reset;
    assign bus.mem_req_addr  = bus.mem_req_valid ? fetch_pc : '0;
    assign req_fire_c        = bus.mem_req_valid & bus.mem_req_ready;

    // Live requests are consecutive since the last redirect, so the oldest one sits outstanding words back
    assign rsp_pc_c    = fetch_pc - (addr_t'(outstanding) << 2);
    assign rsp_stale_c = bus.mem_rsp_valid & (stale != '0);
    assign rsp_live_c  = bus.mem_rsp_valid & (stale == '0) & ~flush;

`ifdef TINKER_FQ_BYPASS_EN
    assign bypass_hit_c = rsp_live_c & (count == '0) & ~reset;
`else
    assign bypass_hit_c = 1'b0;
`endif

    assign push_c     = rsp_live_c & ~(bypass_hit_c & bus.out_ready);
    assign pop_c      = (count != '0) & bus.out_ready & ~flush;
    assign push_entry = '{pc: rsp_pc_c, instr: bus.mem_rsp_data};

    // Decoder-facing view: queue head first, else a forwarded response; zero when idle
    always_comb begin
        out_valid_c = 1'b0;
        out_pc_c    = '0;
        out_instr_c = '0;
        if (!flush) begin
            if (count != '0) begin
                out_valid_c = 1'b1;
                out_pc_c    = head_entry.pc;
                out_instr_c = head_entry.instr;
            end else if (bypass_hit_c) begin
                out_valid_c = 1'b1;
                out_pc_c    = rsp_pc_c;
                out_instr_c = bus.mem_rsp_data;
            end
        end
    end

    assign bus.out_valid = out_valid_c;
    assign bus.out_pc    = out_pc_c;
    assign bus.out_instr = out_instr_c;

    // On redirect every in-flight request becomes stale, minus any response consumed this cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            stale       <= '0;
        end else if (flush) begin
            fetch_pc    <= flush_pc;
            outstanding <= '0;
            stale       <= stale + FQ_STALE_W'(outstanding) - FQ_STALE_W'(bus.mem_rsp_valid);
        end else begin
            if (req_fire_c) begin
                fetch_pc <= fetch_pc + 64'd4;
            end
            outstanding <= outstanding + CNT_W'(req_fire_c) - CNT_W'(rsp_live_c);
            if (rsp_stale_c) begin
                stale <= stale - FQ_STALE_W'(1);
            end
        end
    end

    tinker_fq_ring #(
        .DEPTH (DEPTH)
    ) u_ring (
        .clk        (clk),
        .reset      (reset),
        .clear      (flush),
        .push       (push_c),
        .push_entry (push_entry),
        .pop        (pop_c),
        .head_entry (head_entry),
        .count      (count)
    );

endmodule

// File: tb/tb_tinker_fetch_queue.sv
// Bench for tinker_fetch_queue: directed scenarios plus random traffic against a queue-level reference model.
module tb_tinker_fetch_queue;
    import tinker_pkg::*;

    localparam int unsigned DEPTH = 4;
`ifdef TINKER_FQ_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        addr_t addr;
        bit    live;
        int    cyc;
    } mreq_t;

    logic  clk = 1'b0;
    logic  reset;
    logic  flush;
    logic  halt;
    addr_t flush_pc;

    tinker_fetch_queue_if bus ();

    tinker_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (64'h2000)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .flush_pc (flush_pc),
        .halt     (halt),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int unsigned rdy_pct  = 100;
    int unsigned rsp_pct  = 100;
    int unsigned ordy_pct = 100;

    mreq_t mem_q[$];
    addr_t exp_q[$];
    addr_t req_log[$];
    addr_t out_log[$];
    addr_t m_pc     = 64'h2000;
    bit    m_halted = 1'b0;
    logic  s_out_valid;

    function automatic bit roll(input int unsigned p);
        return $urandom_range(99) < p;
    endfunction

    function automatic instr_t word_of(input addr_t a);
        return {a[17:2], ~a[17:2]} ^ 32'h5a3c_0f00;
    endfunction

    function automatic addr_t pick(input addr_t q[$], input int i);
        return (i < q.size()) ? q[i] : 64'hdead_dead_dead_dead;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, compare against the model, then advance the model
    task automatic step(input logic fl, input addr_t fpc, input logic hl);
        int    live_n = 0;
        bit    rsp_v, rsp_live, byp, e_req_v, e_out_v, acc, take;
        addr_t e_pc, e_addr, rsp_addr;
        flush             = fl;
        flush_pc          = fpc;
        halt              = hl;
        bus.mem_req_ready = roll(rdy_pct);
        bus.out_ready     = roll(ordy_pct);
        rsp_v             = (mem_q.size() > 0) && (mem_q[0].cyc < cyc) && roll(rsp_pct);
        rsp_addr          = rsp_v ? mem_q[0].addr : '0;
        bus.mem_rsp_valid = rsp_v;
        bus.mem_rsp_data  = rsp_v ? word_of(rsp_addr) : instr_t'($urandom);
        #1;
        foreach (mem_q[i]) if (mem_q[i].live) live_n++;
        rsp_live = rsp_v && mem_q[0].live && !fl;
        byp      = BYPASS && rsp_live && (exp_q.size() == 0);
        e_req_v  = !m_halted && !fl && !hl && ((exp_q.size() + live_n) < DEPTH);
        e_addr   = e_req_v ? m_pc : '0;
        e_out_v  = !fl && ((exp_q.size() != 0) || byp);
        e_pc     = !e_out_v ? '0 : (exp_q.size() != 0) ? exp_q[0] : rsp_addr;
        chk("req_valid", 64'(bus.mem_req_valid), 64'(e_req_v));
        chk("req_addr", bus.mem_req_addr, e_addr);
        chk("out_valid", 64'(bus.out_valid), 64'(e_out_v));
        chk("out_pc", bus.out_pc, e_pc);
        chk("out_instr", 64'(bus.out_instr), e_out_v ? 64'(word_of(e_pc)) : 64'h0);
        s_out_valid = bus.out_valid;
        acc  = e_req_v && bus.mem_req_ready;
        take = e_out_v && bus.out_ready;
        if (rsp_v) void'(mem_q.pop_front());
        if (fl) begin
            exp_q.delete();
            foreach (mem_q[i]) mem_q[i].live = 1'b0;
            m_pc     = fpc;
            m_halted = 1'b0;
        end else begin
            if (take) begin
                out_log.push_back(e_pc);
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (rsp_live && !(byp && take)) exp_q.push_back(rsp_addr);
            if (acc) begin
                mem_q.push_back('{addr: m_pc, live: 1'b1, cyc: cyc});
                req_log.push_back(m_pc);
                m_pc = m_pc + 64'd4;
            end
            if (hl) m_halted = 1'b1;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Reset DUT and memory together; outputs must read zero while reset is high
    task automatic do_reset();
        reset             = 1'b1;
        flush             = 1'b0;
        halt              = 1'b0;
        flush_pc          = '0;
        bus.mem_req_ready = 1'b1;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        bus.out_ready     = 1'b1;
        #1;
        chk("rst_req_valid", 64'(bus.mem_req_valid), 64'h0);
        chk("rst_req_addr", bus.mem_req_addr, 64'h0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
        chk("rst_out_instr", 64'(bus.out_instr), 64'h0);
        chk("rst_out_pc", bus.out_pc, 64'h0);
        mem_q.delete();
        exp_q.delete();
        req_log.delete();
        out_log.delete();
        m_pc     = 64'h2000;
        m_halted = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic  fl, hl;
        addr_t fpc;
        reset = 1'b1;
        flush = 1'b0;
        halt  = 1'b0;
        flush_pc = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        bus.out_ready     = 1'b0;
        @(negedge clk);

        // Streaming fetch with ready memory and decoder
        do_reset();
        rdy_pct = 100; rsp_pct = 100; ordy_pct = 100;
        repeat (8) step(1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("t1_req_addr", pick(req_log, i), 64'h2000 + 64'(4 * i));
            chk("t1_out_pc", pick(out_log, i), 64'h2000 + 64'(4 * i));
        end

        // Credit limit with a stalled decoder
        do_reset();
        rdy_pct = 100; rsp_pct = 100; ordy_pct = 0;
        repeat (10) step(1'b0, '0, 1'b0);
        chk("t2_nreq_full", 64'(req_log.size()), 64'd4);
        ordy_pct = 100;
        step(1'b0, '0, 1'b0);
        ordy_pct = 0;
        repeat (6) step(1'b0, '0, 1'b0);
        chk("t2_nreq_after_pop", 64'(req_log.size()), 64'd5);
        chk("t2_nout", 64'(out_log.size()), 64'd1);

        // Redirect with two requests in flight
        do_reset();
        rdy_pct = 100; rsp_pct = 0; ordy_pct = 100;
        repeat (2) step(1'b0, '0, 1'b0);
        rdy_pct = 0;
        step(1'b0, '0, 1'b0);
        chk("t3_inflight", 64'(req_log.size()), 64'd2);
        req_log.delete();
        out_log.delete();
        rdy_pct = 100; rsp_pct = 100;
        step(1'b1, 64'h3000, 1'b0);
        repeat (8) step(1'b0, '0, 1'b0);
        chk("t3_first_req", pick(req_log, 0), 64'h3000);
        chk("t3_nout", 64'(out_log.size() >= 3), 64'h1);
        for (int i = 0; i < out_log.size(); i++) chk("t3_out_pc", out_log[i], 64'h3000 + 64'(4 * i));

        // Halt with three queued entries, drain, then redirect resumes fetch
        do_reset();
        rdy_pct = 100; rsp_pct = 100; ordy_pct = 0;
        repeat (3) step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        ordy_pct = 100;
        repeat (8) step(1'b0, '0, 1'b0);
        chk("t4_nreq_halted", 64'(req_log.size()), 64'd3);
        chk("t4_ndrained", 64'(out_log.size()), 64'd3);
        for (int i = 0; i < 3; i++) chk("t4_drain_pc", pick(out_log, i), 64'h2000 + 64'(4 * i));
        step(1'b1, 64'h2100, 1'b0);
        repeat (6) step(1'b0, '0, 1'b0);
        chk("t4_resume_req", pick(req_log, 3), 64'h2100);
        chk("t4_resume_out", pick(out_log, 3), 64'h2100);

        // Response into an empty queue: forwarding timing
        do_reset();
        rdy_pct = 100; rsp_pct = 100; ordy_pct = 100;
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        chk("t5_rsp_cycle_valid", 64'(s_out_valid), 64'(BYPASS));
        step(1'b0, '0, 1'b0);
        chk("t5_next_cycle_valid", 64'(s_out_valid), 64'h1);

        // Reset with two requests outstanding
        do_reset();
        rdy_pct = 100; rsp_pct = 0; ordy_pct = 100;
        repeat (2) step(1'b0, '0, 1'b0);
        do_reset();
        rsp_pct = 100;
        step(1'b0, '0, 1'b0);
        chk("t6_first_req", pick(req_log, 0), 64'h2000);

        // Random traffic, including a redirect near the top of the address space
        do_reset();
        rdy_pct = 70; rsp_pct = 60; ordy_pct = 60;
        for (int n = 0; n < 400; n++) begin
            fl  = roll(3) || (n == 150);
            hl  = roll(4);
            fpc = (n == 150) ? 64'hffff_ffff_ffff_fff8 : ({$urandom, $urandom} & ~64'h3);
            step(fl, fpc, hl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
